// File: rtl/mux8_rr_sched_if.sv
// Scheduler-side bundle for the shared 8:1 mux: requests and mux output in,
// select, grant and tagged sample out.
interface mux8_rr_sched_if;
    logic [7:0] req;
    logic       y;
    logic [2:0] s;
    logic [7:0] gnt;
    logic       dout;
    logic       dvalid;
    logic [2:0] dtag;
    logic       busy;

    modport master (
        input  req, y,
        output s, gnt, dout, dvalid, dtag, busy
    );

    modport slave (
        output req, y,
        input  s, gnt, dout, dvalid, dtag, busy
    );
endinterface

// File: rtl/mux8_rr_sched.sv
// Round-robin owner of the 8:1 mux select: grants a requester, waits SETTLE
// cycles for the mux path, then samples Y for up to MAX_BURST cycles.
module mux8_rr_sched #(
    parameter int unsigned SETTLE    = 1,
    parameter int unsigned MAX_BURST = 4
) (
    input logic            clk,
    input logic            rst_n,
    mux8_rr_sched_if.master bus
);
    localparam logic [3:0] SETTLE_V = 4'(SETTLE);
    localparam logic [3:0] BURST_V  = 4'(MAX_BURST);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE} state_t;

    state_t     state;
    logic [2:0] ptr, w, s_q, dtag_q;
    logic [3:0] scnt, bcnt;
    logic [7:0] gnt_q;
    logic       dout_q, dvalid_q, busy_q;

    logic [2:0] base, idx, win;
    logic       any, release_now, arb_edge;

    // On a release edge PTR takes W in the same cycle, so search from W there.
    always_comb begin
        base = (state == ST_IDLE) ? ptr : w;
        any  = 1'b0;
        win  = base;
        idx  = base;
        for (int unsigned i = 1; i <= 8; i++) begin
            idx = 3'(base + 3'(i));
            if (!any && bus.req[idx]) begin
                any = 1'b1;
                win = idx;
            end
        end
    end

    always_comb begin
        release_now = 1'b0;
        case (state)
            ST_SETTLE: release_now = !bus.req[w];
            ST_SAMPLE: release_now = !bus.req[w] || (4'(bcnt + 4'd1) == BURST_V);
            default:   release_now = 1'b0;
        endcase
        arb_edge = (state == ST_IDLE) || release_now;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= 3'd7;
            w        <= '0;
            s_q      <= '0;
            gnt_q    <= '0;
            scnt     <= '0;
            bcnt     <= '0;
            dout_q   <= 1'b0;
            dvalid_q <= 1'b0;
            dtag_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            dvalid_q <= 1'b0;

            if (state == ST_SAMPLE && bus.req[w]) begin
                dout_q   <= bus.y;
                dtag_q   <= w;
                dvalid_q <= 1'b1;
                bcnt     <= 4'(bcnt + 4'd1);
            end

            if (state == ST_SETTLE && bus.req[w]) begin
                if (scnt <= 4'd1) state <= ST_SAMPLE;
                else              scnt  <= 4'(scnt - 4'd1);
            end

            // A release and the next grant share one edge; later writes win.
            if (arb_edge) begin
                if (state != ST_IDLE) ptr <= w;
                if (any) begin
                    w      <= win;
                    s_q    <= win;
                    gnt_q  <= 8'(1) << win;
                    scnt   <= SETTLE_V;
                    bcnt   <= '0;
                    busy_q <= 1'b1;
                    state  <= (SETTLE_V == 4'd0) ? ST_SAMPLE : ST_SETTLE;
                end else begin
                    gnt_q  <= '0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            end
        end
    end

    assign bus.s      = s_q;
    assign bus.gnt    = gnt_q;
    assign bus.dout   = dout_q;
    assign bus.dvalid = dvalid_q;
    assign bus.dtag   = dtag_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_mux8_rr_sched.sv
// Directed bench for mux8_rr_sched: two instances (SETTLE=1 and SETTLE=3),
// hand-computed grant order, latency, burst and abort expectations.
module tb_mux8_rr_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    mux8_rr_sched_if bus1();
    mux8_rr_sched_if bus3();

    mux8_rr_sched #(.SETTLE(1), .MAX_BURST(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    mux8_rr_sched #(.SETTLE(3), .MAX_BURST(4)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus1.req = '0;
        bus3.req = '0;
        bus1.y   = 1'b0;
        bus3.y   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Entered just after a grant edge of u_dut: one settle cycle, four samples.
    task automatic run_grant(input logic [2:0] idx, input logic [7:0] pat);
        chk("grant_gnt", 32'(bus1.gnt), 32'(8'(1) << idx));
        chk("grant_s", 32'(bus1.s), 32'(idx));
        chk("grant_busy", 32'(bus1.busy), 32'd1);
        tick();
        chk("settle_dvalid", 32'(bus1.dvalid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            bus1.y = pat[k];
            tick();
            chk("sample_dvalid", 32'(bus1.dvalid), 32'd1);
            chk("sample_dtag", 32'(bus1.dtag), 32'(idx));
            chk("sample_dout", 32'(bus1.dout), 32'(pat[k]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset then idle
        rst_n    = 1'b0;
        bus1.req = '0;
        bus3.req = '0;
        bus1.y   = 1'b0;
        bus3.y   = 1'b0;
        repeat (3) tick();
        chk("rst_gnt", 32'(bus1.gnt), 32'h0);
        chk("rst_s", 32'(bus1.s), 32'h0);
        chk("rst_dvalid", 32'(bus1.dvalid), 32'h0);
        chk("rst_dout", 32'(bus1.dout), 32'h0);
        chk("rst_dtag", 32'(bus1.dtag), 32'h0);
        chk("rst_busy", 32'(bus1.busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_gnt", 32'(bus1.gnt), 32'h0);
        chk("idle_busy", 32'(bus1.busy), 32'h0);

        // Single requester 3: two bursts separated by one dead cycle
        do_reset();
        bus1.req = 8'h08;
        tick();
        run_grant(3'd3, 8'b0000_0101);
        run_grant(3'd3, 8'b0000_1010);
        bus1.req = 8'h00;
        tick();
        chk("single_drop_gnt", 32'(bus1.gnt), 32'h0);
        chk("single_drop_busy", 32'(bus1.busy), 32'h0);
        chk("single_drop_dvalid", 32'(bus1.dvalid), 32'h0);
        chk("single_drop_s_hold", 32'(bus1.s), 32'd3);

        // Fairness: all requesting, order 0..7 then 0
        do_reset();
        bus1.req = 8'hFF;
        tick();
        for (int g = 0; g < 9; g++)
            run_grant(3'(g), 8'(8'hA5 ^ 8'(g * 37)));
        bus1.req = 8'h00;

        // Priority after wrap: 0x81 from reset gives 0, 7, 0
        do_reset();
        bus1.req = 8'h81;
        tick();
        run_grant(3'd0, 8'b0000_0110);
        run_grant(3'd7, 8'b0000_1001);
        run_grant(3'd0, 8'b0000_0011);
        bus1.req = 8'h00;

        // Abort during settle on the SETTLE=3 instance
        do_reset();
        bus3.req = 8'h04;
        tick();
        chk("abort_grant_gnt", 32'(bus3.gnt), 32'h04);
        chk("abort_grant_s", 32'(bus3.s), 32'd2);
        chk("abort_grant_busy", 32'(bus3.busy), 32'd1);
        bus3.req = 8'h00;
        tick();
        chk("abort_gnt", 32'(bus3.gnt), 32'h00);
        chk("abort_busy", 32'(bus3.busy), 32'd0);
        chk("abort_dvalid", 32'(bus3.dvalid), 32'd0);
        chk("abort_s_hold", 32'(bus3.s), 32'd2);
        bus3.req = 8'h06;
        bus3.y   = 1'b1;
        tick();
        chk("abort_next_gnt", 32'(bus3.gnt), 32'h02);
        chk("abort_next_s", 32'(bus3.s), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_next_settle", 32'(bus3.dvalid), 32'd0);
        end
        tick();
        chk("abort_next_dvalid", 32'(bus3.dvalid), 32'd1);
        chk("abort_next_dtag", 32'(bus3.dtag), 32'd1);
        chk("abort_next_dout", 32'(bus3.dout), 32'd1);
        bus3.req = 8'h00;

        // Asynchronous reset mid-burst
        do_reset();
        bus1.req = 8'h01;
        bus1.y   = 1'b1;
        tick();
        chk("ar_gnt", 32'(bus1.gnt), 32'h01);
        tick();
        chk("ar_settle", 32'(bus1.dvalid), 32'd0);
        tick();
        chk("ar_sample", 32'(bus1.dvalid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_async_gnt", 32'(bus1.gnt), 32'h00);
        chk("ar_async_dvalid", 32'(bus1.dvalid), 32'd0);
        chk("ar_async_busy", 32'(bus1.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("ar_regrant_gnt", 32'(bus1.gnt), 32'h01);
        chk("ar_regrant_dvalid", 32'(bus1.dvalid), 32'd0);
        tick();
        chk("ar_resettle", 32'(bus1.dvalid), 32'd0);
        tick();
        chk("ar_first_sample", 32'(bus1.dvalid), 32'd1);
        chk("ar_first_dtag", 32'(bus1.dtag), 32'd0);
        chk("ar_first_dout", 32'(bus1.dout), 32'd1);
        bus1.req = 8'h00;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mux8_rr_sched.md
# mux8_rr_sched

Round-robin scheduler that shares the 8:1 data-select mux among eight requesters. It drives the mux select lines, waits a programmable settle interval for the gate-level mux path to resolve, then samples the mux output Y into a registered data output tagged with the source index. It sits directly in front of the mux, owns S2..S0, and is the only agent allowed to change them.

## Interface
- SETTLE, 1, full clock cycles between a select change and the first sample of Y; range 0..15.
- MAX_BURST, 4, maximum consecutive samples per grant before forced rotation; range 1..15.
- CLK  in  1  single clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- REQ  in  8  REQ[i] requests sampling of mux input Ii; level-sensitive, held for as long as samples are wanted.
- Y  in  1  mux output.
- S  out  3  mux select {S2,S1,S0}, registered.
- GNT  out  8  one-hot grant, registered; all-zero when idle.
- DOUT  out  1  sampled Y, registered.
- DVALID  out  1  high for one cycle per sample taken.
- DTAG  out  3  index of the requester that DOUT belongs to.
- BUSY  out  1  high in SETTLE and SAMPLE.

## Operation
- States: IDLE, SETTLE, SAMPLE. Internal: round-robin pointer PTR (3 bits), settle counter SCNT (4 bits), burst counter BCNT (4 bits), winner W (3 bits).
- Arbitration, combinational: search REQ starting at PTR+1 (mod 8), wrapping; the first set bit wins. The last winner has lowest priority and can only win again if no one else is requesting.
- IDLE: if REQ != 0, load W/S/GNT with the winner, set SCNT=SETTLE, set BCNT=0, and go to SETTLE, or to SAMPLE if SETTLE=0. Otherwise stay in IDLE with GNT=0.
- SETTLE: if REQ[W]=0, release (abort, no sample). Else, if SCNT<=1, go to SAMPLE. Else decrement SCNT.
- SAMPLE, each edge: if REQ[W]=0, release with no sample. Else DOUT<=Y, DTAG<=W, DVALID<=1, BCNT<=BCNT+1; if BCNT+1=MAX_BURST, release after this sample.
- Release: PTR<=W, and arbitrate in the same edge with the updated priority.
  - If another request wins, load the new W/S/GNT and enter SETTLE (or SAMPLE if SETTLE=0), with no idle cycle.
  - If only W still requests after burst expiry, re-grant W; it passes through SETTLE again.
  - If no requests remain, set GNT=0 and go to IDLE. S holds its last value.
- DVALID is 0 on every edge where no sample is taken.
- S changes only on a grant edge and never while in SAMPLE.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, S=0, GNT=0, DOUT=0, DVALID=0, DTAG=0, BUSY=0, PTR=7 (requester 0 has first priority), SCNT=0, BCNT=0.
- Reset mid-grant drops GNT and DVALID at once. Partial settle or burst progress is discarded.
- Latency: if REQ is sampled at edge k in IDLE, GNT/S are valid after edge k and the first DVALID appears after edge k+SETTLE+1 (SETTLE=1 gives 2 cycles).
- A sustained single requester gets MAX_BURST samples, then SETTLE dead cycles, then MAX_BURST more.
- Rotation gap between two requesters: SETTLE cycles with DVALID=0.
- REQ deassertion is seen at the next edge. No sample is taken on that edge and a new grant may issue on it.
- Simultaneous requests are resolved purely by PTR order. A requester is never starved: its wait is at most 7·(SETTLE+MAX_BURST) cycles.

## Test plan
- Reset then idle: RST_N low for 3 cycles, REQ=0 -> all outputs 0, BUSY=0; after release, GNT stays 0.
- Single requester: SETTLE=1, MAX_BURST=4, REQ=0x08, Y toggling -> S=3 and GNT=0x08 after first edge. DVALID is high on 4 edges with DTAG=3 and DOUT matching Y at each edge, then 1 dead cycle, then repeats.
- Round-robin fairness: REQ=0xFF held -> grant order 0,1,…,7,0 with 4 samples each. DTAG sequence matches, and there is exactly 1 DVALID-low cycle per rotation.
- Priority after wrap: PTR=7 from reset, REQ=0x81 -> grant 0 first, then 7, then 0.
- Abort during settle: SETTLE=3, REQ=0x04, drop REQ after 1 cycle -> no DVALID, GNT=0, IDLE. Next REQ=0x06 grants 1 (PTR=2 after abort, so 3 is searched first, then 4..7, 0, 1).
- Async reset mid-burst: assert RST_N low between edges during SAMPLE -> GNT, DVALID, BUSY go 0 without waiting for CLK. After release with REQ=0x01, the first sample is at edge SETTLE+1.
